sprite_fetch_sched: RTL

Per-pixel sprite fetch scheduler between the VGA pixel counter and the sprite ROMs (mario, block, coin, brick, digits 0–3). It holds an 8-slot object table, finds the highest-priority object covering each requested pixel, and drives one shared registered address to all ROMs. It then selects the returned ROM word by object kind and emits a palette index with a per-kind tag. It is fully pipelined at one pixel per clock. Object-table updates are double-buffered and take effect only at frame boundaries.

---
 rtl/sprite_pkg.sv | 61 ++++++
 rtl/sprite_slot_match.sv | 55 +++++
 rtl/sprite_fetch_sched.sv | 126 ++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types for the sprite fetch scheduler.
// Object kinds, sprite geometry and the object-table entry.
package sprite_pkg;

    localparam int NUM_SLOTS = 8;
    localparam int SLOT_W    = $clog2(NUM_SLOTS);

    typedef enum logic [3:0] {
        KIND_NONE  = 4'd0,
        KIND_MARIO = 4'd1,
        KIND_BLOCK = 4'd2,
        KIND_COIN  = 4'd3,
        KIND_BRICK = 4'd4,
        KIND_DIG0  = 4'd5,
        KIND_DIG1  = 4'd6,
        KIND_DIG2  = 4'd7,
        KIND_DIG3  = 4'd8
    } sprite_kind_t;

    localparam logic [5:0] MARIO_W = 6'd26;
    localparam logic [5:0] MARIO_H = 6'd32;
    localparam logic [5:0] COIN_W  = 6'd28;
    localparam logic [5:0] COIN_H  = 6'd32;
    localparam logic [5:0] TILE_W  = 6'd32;
    localparam logic [5:0] TILE_H  = 6'd32;

    typedef struct packed {
        sprite_kind_t kind;
        logic [9:0]   x;
        logic [9:0]   y;
    } obj_t;

    // Encodings above DIG3 are unused and behave as an empty slot.
    function automatic sprite_kind_t kind_norm(input logic [3:0] k);
        sprite_kind_t r;
        if (k > 4'd8) r = KIND_NONE;
        else          r = sprite_kind_t'(k);
        return r;
    endfunction

    function automatic logic [5:0] kind_w(input sprite_kind_t k);
        logic [5:0] w;
        case (k)
            KIND_MARIO: w = MARIO_W;
            KIND_COIN:  w = COIN_W;
            default:    w = TILE_W;
        endcase
        return w;
    endfunction

    function automatic logic [5:0] kind_h(input sprite_kind_t k);
        logic [5:0] h;
        case (k)
            KIND_MARIO: h = MARIO_H;
            KIND_COIN:  h = COIN_H;
            default:    h = TILE_H;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sprite_slot_match.sv
// Per-slot coverage test, priority pick and ROM address for one pixel.
// Purely combinational; the caller registers the result.
module sprite_slot_match
    import sprite_pkg::*;
(
    input  obj_t [NUM_SLOTS-1:0] tbl,
    input  logic [9:0]           pix_x,
    input  logic [9:0]           pix_y,
    output logic                 hit,
    output sprite_kind_t         kind,
    output logic [9:0]           addr
);

    logic [NUM_SLOTS-1:0] slot_hit;
    logic [4:0]           row [NUM_SLOTS];
    logic [4:0]           col [NUM_SLOTS];
    logic [SLOT_W-1:0]    sel;

    // 11-bit bounds keep a sprite near x=1023 from wrapping to x=0.
    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slot_hit[i] = (tbl[i].kind != KIND_NONE)
                && ({1'b0, pix_x} >= {1'b0, tbl[i].x})
                && ({1'b0, pix_x} <
                    {1'b0, tbl[i].x} + {5'd0, kind_w(tbl[i].kind)})
                && ({1'b0, pix_y} >= {1'b0, tbl[i].y})
                && ({1'b0, pix_y} <
                    {1'b0, tbl[i].y} + {5'd0, kind_h(tbl[i].kind)});
            col[i] = pix_x[4:0] - tbl[i].x[4:0];
            row[i] = pix_y[4:0] - tbl[i].y[4:0];
        end
    end

    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (slot_hit[i]) begin
                hit = 1'b1;
                sel = i[SLOT_W-1:0];
            end
        end
    end

    always_comb begin
        kind = KIND_NONE;
        addr = '0;
        if (hit) begin
            kind = tbl[sel].kind;
            addr = {5'd0, row[sel]} * {4'd0, kind_w(tbl[sel].kind)}
                 + {5'd0, col[sel]};
        end
    end

endmodule

// File: rtl/sprite_fetch_sched.sv
// Sprite fetch scheduler: double-buffered object table feeding a
// three-stage lookup / ROM fetch / palette-select pipeline.
module sprite_fetch_sched
    import sprite_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       obj_we,
    input  logic [2:0] obj_idx,
    input  logic [3:0] obj_kind,
    input  logic [9:0] obj_x,
    input  logic [9:0] obj_y,
    input  logic       obj_commit,
    input  logic       frame_start,
    input  logic       pix_req,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    output logic [9:0] rom_addr,
    input  logic [2:0] mario_q,
    input  logic [1:0] block_q,
    input  logic [1:0] coin_q,
    input  logic [2:0] brick_q,
    input  logic [7:0] digit_q,
    output logic       pix_valid,
    output logic       pix_hit,
    output logic [3:0] pix_kind,
    output logic [2:0] pix_idx,
    output logic       commit_pending
);

    obj_t [NUM_SLOTS-1:0] shadow_tbl;
    obj_t [NUM_SLOTS-1:0] active_tbl;
    obj_t                 wr_obj;
    logic                 do_copy;

    assign do_copy = frame_start & (commit_pending | obj_commit);
    assign wr_obj  = '{kind: kind_norm(obj_kind), x: obj_x, y: obj_y};

    // The copy reads shadow before a same-edge write lands in it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_tbl     <= '0;
            active_tbl     <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (do_copy)
                active_tbl <= shadow_tbl;
            if (obj_we)
                shadow_tbl[obj_idx] <= wr_obj;
            commit_pending <= do_copy ? 1'b0
                                      : (commit_pending | obj_commit);
        end
    end

    logic         m_hit;
    sprite_kind_t m_kind;
    logic [9:0]   m_addr;

    sprite_slot_match u_match (
        .tbl   (active_tbl),
        .pix_x (pix_x),
        .pix_y (pix_y),
        .hit   (m_hit),
        .kind  (m_kind),
        .addr  (m_addr)
    );

    logic         s1_valid;
    logic         s2_valid;
    sprite_kind_t s1_kind;
    sprite_kind_t s2_kind;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_addr <= '0;
            s1_valid <= 1'b0;
            s1_kind  <= KIND_NONE;
            s2_valid <= 1'b0;
            s2_kind  <= KIND_NONE;
        end else begin
            s1_valid <= pix_req;
            if (pix_req) begin
                rom_addr <= m_addr;
                s1_kind  <= m_hit ? m_kind : KIND_NONE;
            end
            s2_valid <= s1_valid;
            s2_kind  <= s1_kind;
        end
    end

    logic [2:0] q_sel;
    logic       opaque;

    always_comb begin
        q_sel = '0;
        case (s2_kind)
            KIND_MARIO: q_sel = mario_q;
            KIND_BLOCK: q_sel = {1'b0, block_q};
            KIND_COIN:  q_sel = {1'b0, coin_q};
            KIND_BRICK: q_sel = brick_q;
            KIND_DIG0:  q_sel = {1'b0, digit_q[1:0]};
            KIND_DIG1:  q_sel = {1'b0, digit_q[3:2]};
            KIND_DIG2:  q_sel = {1'b0, digit_q[5:4]};
            KIND_DIG3:  q_sel = {1'b0, digit_q[7:6]};
            default:    q_sel = '0;
        endcase
    end

    // Index 0 is transparent; no fall-through to lower slots.
    assign opaque = s2_valid & (q_sel != 3'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_valid <= 1'b0;
            pix_hit   <= 1'b0;
            pix_kind  <= KIND_NONE;
            pix_idx   <= '0;
        end else begin
            pix_valid <= s2_valid;
            pix_hit   <= opaque;
            pix_kind  <= opaque ? s2_kind : KIND_NONE;
            pix_idx   <= opaque ? q_sel : 3'd0;
        end
    end

endmodule
